code_decoder: RTL
=================

CODE_DECODER -- requirements
Module: code_decoder

Interface
REQ-001 SHALL have parameter PULSE_LEN, default 4, number of cycles each decoded output is held (legal 1..255).
REQ-002 SHALL have parameter CNT_W, default 8, width of the internal hold counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port code  input  2  encoded index to expand (0..3).
REQ-006 SHALL have port valid  input  1  code is valid this cycle.
REQ-007 SHALL have port ready  output  1  block can accept a code this cycle.
REQ-008 SHALL have port y  output  4  decoded output, registered.
REQ-009 SHALL have port busy  output  1  decoded output currently being driven.
REQ-010 SHALL have port done  output  1  one-cycle pulse on last cycle of a hold.

Function
REQ-011 SHALL accept a code only on a cycle where valid=1 and ready=1 (transfer); no other cycle changes captured code.
REQ-012 SHALL implement FSM with states IDLE and ACTIVE.
REQ-013 SHALL, in IDLE, drive y=4'b0000, busy=0, done=0, ready=1.
REQ-014 SHALL, on a transfer in IDLE, enter ACTIVE next cycle with counter loaded to PULSE_LEN-1.
REQ-015 SHALL, in ACTIVE, drive y=decode(captured code), busy=1; latency from transfer cycle to first y cycle is exactly 1.
REQ-016 SHALL decrement counter every ACTIVE cycle; last cycle is counter==0.
REQ-017 SHALL assert done=1 only on the last ACTIVE cycle.
REQ-018 SHALL drive ready=1 in ACTIVE only on the last cycle; ready=0 on all other ACTIVE cycles.
REQ-019 SHALL, on a transfer during the last ACTIVE cycle, stay in ACTIVE with new code and reloaded counter (zero-bubble back-to-back).
REQ-020 SHALL, on last ACTIVE cycle without transfer, return to IDLE next cycle.
REQ-021 SHALL ignore valid while ready=0; code/valid changes then have no effect.
REQ-022 SHALL, for PULSE_LEN=1, hold y exactly one cycle with done and ready both high in that cycle.
REQ-023 SHALL keep y strictly one of {0001,0010,0100,1000} or 0000 in default build; code 0->0001, 1->0010, 2->0100, 3->1000.

Reset
REQ-024 SHALL, when rst=1 at a clock edge, force IDLE, counter=0, captured code=0, y=0000, busy=0, done=0, ready=1 next cycle.
REQ-025 SHALL give rst priority over any simultaneous transfer; a code presented in the reset cycle is discarded.
REQ-026 SHALL abort an in-progress hold on reset without asserting done.

Configuration
REQ-027 SHALL use macro CODE_DECODER_THERMO_EN to select output mapping.
REQ-028 SHALL, without CODE_DECODER_THERMO_EN, produce one-hot y per REQ-023.
REQ-029 SHALL, with CODE_DECODER_THERMO_EN, produce thermometer y (all bits at and below code set): 0->0001, 1->0011, 2->0111, 3->1111; all timing unchanged.

Verification
REQ-030 SHALL cover: reset, then code=2 valid one cycle, PULSE_LEN=4 -> y=0100 for exactly 4 cycles starting 1 cycle later, done on 4th, then y=0000.
REQ-031 SHALL cover: valid held high with codes 0,3 back-to-back, second presented on done cycle -> y=0001 x4 then 1000 x4, no gap cycle.
REQ-032 SHALL cover: valid=1 code=1 during non-last ACTIVE cycles -> ignored, ready=0, y unchanged.
REQ-033 SHALL cover: rst=1 on 2nd ACTIVE cycle of code=3 -> next cycle y=0000, busy=0, ready=1, no done pulse.
REQ-034 SHALL cover: PULSE_LEN=1, codes 0..3 streamed -> y 0001,0010,0100,1000 on consecutive cycles, done every cycle.
REQ-035 SHALL cover: CODE_DECODER_THERMO_EN defined, code=2 -> y=0111 for PULSE_LEN cycles.

Source files
------------

// File: rtl/code_decoder.sv
// Code decoder: expands a 2-bit code into a 4-bit pattern held on y for PULSE_LEN cycles.
// Handshake is valid/ready. A new code can be accepted on the last hold cycle, so holds
// can follow each other with no gap.
// Optional feature macro: CODE_DECODER_THERMO_EN. When it is defined, y is a thermometer
// code. When it is undefined, y is one-hot.
module code_decoder #(
    parameter int unsigned PULSE_LEN = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] code,
    input  logic       valid,
    output logic       ready,
    output logic [3:0] y,
    output logic       busy,
    output logic       done
);

    typedef enum logic {
        StIdle,
        StActive
    } state_e;

    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(PULSE_LEN - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       code_q, code_d;
    logic [3:0]       y_q, y_d;
    logic             last;
    logic             xfer;

    // Map a code index to its output pattern.
    function automatic logic [3:0] expand(input logic [1:0] c);
        logic [3:0] r;
`ifdef CODE_DECODER_THERMO_EN
        unique case (c)
            2'd0:    r = 4'b0001;
            2'd1:    r = 4'b0011;
            2'd2:    r = 4'b0111;
            default: r = 4'b1111;
        endcase
`else
        unique case (c)
            2'd0:    r = 4'b0001;
            2'd1:    r = 4'b0010;
            2'd2:    r = 4'b0100;
            default: r = 4'b1000;
        endcase
`endif
        return r;
    endfunction

    // Handshake and status outputs, derived only from registered state.
    always_comb begin
        last  = (state_q == StActive) && (cnt_q == '0);
        ready = (state_q == StIdle) || last;
        busy  = (state_q == StActive);
        done  = last;
        xfer  = valid && ready;
        y     = y_q;
    end

    // Next-state logic. A transfer always (re)loads the hold, whether it comes from idle
    // or from the last active cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        y_d     = y_q;
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    state_d = StActive;
                    cnt_d   = CntLoad;
                    code_d  = code;
                    y_d     = expand(code);
                end
            end
            StActive: begin
                if (last) begin
                    if (xfer) begin
                        cnt_d  = CntLoad;
                        code_d = code;
                        y_d    = expand(code);
                    end else begin
                        state_d = StIdle;
                        y_d     = 4'b0000;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                y_d     = 4'b0000;
            end
        endcase
    end

    // State registers. Reset takes priority over any transfer in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            code_q  <= 2'd0;
            y_q     <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            y_q     <= y_d;
        end
    end

endmodule
